// File: rtl/mips_mem_pkg.sv
// Shared data-memory definitions: access size encodings, responder FSM
// state encoding, and the byte-enable / alignment helpers used by both the
// responder and the core's load/store path.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_t;

  // Little-endian byte enables for an access of the given size at byte
  // offset lane. Reserved size yields no enables.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Reserved size or a half/word access not naturally aligned.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lane);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = lane[0];
      SZ_WORD: f = |lane;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dm_resp_if.sv
// Request/response channel between the core memory stage and the data
// memory responder. master = core side, slave = responder side.
// Request: valid/ready with wr/size/sign/addr/wdata; response: valid/ready
// with rdata/err.
interface dm_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_sign, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_sign, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lane_ext.sv
// Combinational load lane extraction with sign/zero extension.
// Ports: word (raw memory word), size, sign (1 = sign-extend), lane
// (byte offset addr[1:0]) -> data (extended result, 0 for reserved size).
module dm_lane_ext
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign & half_sel[15]}}, half_sel};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: single-outstanding load/store over dm_resp_if with
// WAIT_CYC wait states, byte/half/word lanes, extension and alignment faults.
// Ports: clk, rst (async active-high), bus (dm_resp_if.slave); with
// DM_STAT_EN defined also stat_rd/stat_wr/stat_err saturating counters.
module dm_resp
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  dm_resp_if.slave    bus
`ifdef DM_STAT_EN
  ,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_err
`endif
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);

  dm_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic               lat_wr;
  logic [1:0]         lat_size;
  logic               lat_sign;
  logic [1:0]         lat_lane;
  logic [ADDR_W-1:0]  lat_idx;
  logic [31:0]        lat_wdata;
  logic               lat_fault;

  logic [31:0]        mem [2**ADDR_W];
  logic [31:0]        rd_word;
  logic [31:0]        ext_data;
  logic [31:0]        wr_lanes;
  logic [3:0]         wr_be;
  logic               access_done;
  logic               mem_we;

  // Address bits above the memory wrap around and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign access_done = (state == ST_ACCESS) && (cnt == '0);
  // Gated by state, so an async reset before the completion edge drops the store.
  assign mem_we      = access_done && lat_wr && !lat_fault;
  assign wr_be       = byte_en(lat_size, lat_lane);
  assign rd_word     = mem[lat_idx];

  // Replicate store data so the addressed lane always carries the low bits.
  always_comb begin
    case (lat_size)
      SZ_BYTE: wr_lanes = {4{lat_wdata[7:0]}};
      SZ_HALF: wr_lanes = {2{lat_wdata[15:0]}};
      default: wr_lanes = lat_wdata;
    endcase
  end

  dm_lane_ext u_ext (
    .word (rd_word),
    .size (lat_size),
    .sign (lat_sign),
    .lane (lat_lane),
    .data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[lat_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      lat_wr      <= 1'b0;
      lat_size    <= SZ_BYTE;
      lat_sign    <= 1'b0;
      lat_lane    <= '0;
      lat_idx     <= '0;
      lat_wdata   <= '0;
      lat_fault   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_wr      <= bus.req_wr;
            lat_size    <= bus.req_size;
            lat_sign    <= bus.req_sign;
            lat_lane    <= bus.req_addr[1:0];
            lat_idx     <= bus.req_addr[ADDR_W+1:2];
            lat_wdata   <= bus.req_wdata;
            lat_fault   <= size_fault(bus.req_size, bus.req_addr[1:0]);
            cnt         <= CNT_INIT;
            req_ready_q <= 1'b0;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            // Memory word is read and extended straight into the response register.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= lat_fault;
            rsp_rdata_q <= (lat_fault || lat_wr) ? 32'h0 : ext_data;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DM_STAT_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else if (rsp_hs) begin
      if (lat_fault) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else if (lat_wr) begin
        if (stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
      end else begin
        if (stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_resp.sv
module tb_dm_resp;
  import mips_mem_pkg::*;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    bit          sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } txn_t;

  typedef struct {
    string       name;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_resp_if if1 ();
  dm_resp_if if3 ();

`ifdef DM_STAT_EN
  logic [15:0] s1_rd, s1_wr, s1_err, s3_rd, s3_wr, s3_err;
`endif

  dm_resp #(.ADDR_W(10), .WAIT_CYC(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
`ifdef DM_STAT_EN
    , .stat_rd (s1_rd), .stat_wr (s1_wr), .stat_err (s1_err)
`endif
  );

  dm_resp #(.ADDR_W(10), .WAIT_CYC(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
`ifdef DM_STAT_EN
    , .stat_rd (s3_rd), .stat_wr (s3_wr), .stat_err (s3_err)
`endif
  );

  function automatic txn_t mk(input bit wr, input logic [1:0] size, input bit sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit exp_err);
    txn_t t;
    t.wr = wr; t.size = size; t.sign = sign; t.addr = addr; t.wdata = wdata;
    t.exp_rdata = exp_rdata; t.exp_err = exp_err;
    return t;
  endfunction

  function automatic exp_t mk_exp(input string name, input int lat, input txn_t t);
    exp_t e;
    e.name = name; e.lat = lat; e.rdata = t.exp_rdata; e.err = t.exp_err;
    return e;
  endfunction

  task automatic set_req(input int w, input bit v, input txn_t t);
    if (w == 1) begin
      if1.req_valid = v; if1.req_wr = t.wr; if1.req_size = t.size;
      if1.req_sign = t.sign; if1.req_addr = t.addr; if1.req_wdata = t.wdata;
    end else begin
      if3.req_valid = v; if3.req_wr = t.wr; if3.req_size = t.size;
      if3.req_sign = t.sign; if3.req_addr = t.addr; if3.req_wdata = t.wdata;
    end
  endtask

  task automatic set_rsp_ready(input int w, input bit b);
    if (w == 1) if1.rsp_ready = b;
    else        if3.rsp_ready = b;
  endtask

  task automatic sample(input int w, output logic v, output logic r,
                        output logic [31:0] d, output logic e);
    if (w == 1) begin
      v = if1.rsp_valid; r = if1.req_ready; d = if1.rsp_rdata; e = if1.rsp_err;
    end else begin
      v = if3.rsp_valid; r = if3.req_ready; d = if3.rsp_rdata; e = if3.rsp_err;
    end
  endtask

  // Issue one request; lat counts falling edges after the accepting rising
  // edge until rsp_valid is seen. Leaves the response un-acknowledged if hold.
  task automatic issue(input int w, input txn_t t, output int lat,
                       output logic [31:0] rd, output logic er);
    logic v, r;
    int   n;
    @(negedge clk);
    sample(w, v, r, rd, er);
    n = 0;
    while (!r && n < 50) begin
      @(negedge clk); sample(w, v, r, rd, er); n++;
    end
    set_req(w, 1'b1, t);
    @(negedge clk);
    set_req(w, 1'b0, t);
    lat = 1;
    sample(w, v, r, rd, er);
    while (!v && lat < 50) begin
      @(negedge clk); lat++; sample(w, v, r, rd, er);
    end
    if (n >= 50) lat = -1;
  endtask

  task automatic run_txn(input int w, input txn_t t, output int lat,
                         output logic [31:0] rd, output logic er);
    issue(w, t, lat, rd, er);
    set_rsp_ready(w, 1'b1);
    @(negedge clk);
    set_rsp_ready(w, 1'b0);
  endtask

  task automatic test_reset;
    txn_t z;
    logic v, r, e;
    logic [31:0] d;
    z = mk(0, SZ_BYTE, 0, 0, 0, 0, 0);
    rst = 1'b1;
    set_req(1, 1'b0, z); set_req(3, 1'b0, z);
    set_rsp_ready(1, 1'b0); set_rsp_ready(3, 1'b0);
    repeat (3) @(negedge clk);
    for (int w = 1; w <= 3; w += 2) begin
      sample(w, v, r, d, e);
      checks++; if (r !== 1'b1) $display("FAIL reset_req_ready[%0d] got %b want 1", w, r); else passes++;
      checks++; if (v !== 1'b0) $display("FAIL reset_rsp_valid[%0d] got %b want 0", w, v); else passes++;
      checks++; if (d !== 32'h0) $display("FAIL reset_rsp_rdata[%0d] got %h want 0", w, d); else passes++;
      checks++; if (e !== 1'b0) $display("FAIL reset_rsp_err[%0d] got %b want 0", w, e); else passes++;
    end
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag, input int w, input txn_t t[$]);
    int lat;
    logic [31:0] rd;
    logic er;
    exp_t e;
    for (int i = 0; i < t.size(); i++) begin
      sb.push_back(mk_exp($sformatf("%s[%0d]", tag, i), (w == 1) ? 2 : 4, t[i]));
      run_txn(w, t[i], lat, rd, er);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) $display("FAIL %s latency got %0d want %0d", e.name, lat, e.lat); else passes++;
      checks++; if (rd !== e.rdata) $display("FAIL %s rdata got %h want %h", e.name, rd, e.rdata); else passes++;
      checks++; if (er !== e.err) $display("FAIL %s err got %b want %b", e.name, er, e.err); else passes++;
    end
  endtask

  task automatic test_load_store;
    txn_t t[$];
    t.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    t.push_back(mk(0, SZ_WORD, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    t.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'h11223344, 32'h0, 0));
    t.push_back(mk(1, SZ_BYTE, 0, 32'h13, 32'h000000F0, 32'h0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hF0223344, 0));
    t.push_back(mk(0, SZ_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFFF0, 0));
    t.push_back(mk(0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h000000F0, 0));
    t.push_back(mk(0, SZ_BYTE, 1, 32'h10, 32'h0, 32'h00000044, 0));
    t.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'h80017FFF, 32'h0, 0));
    t.push_back(mk(0, SZ_HALF, 1, 32'h12, 32'h0, 32'hFFFF8001, 0));
    t.push_back(mk(0, SZ_HALF, 0, 32'h12, 32'h0, 32'h00008001, 0));
    t.push_back(mk(0, SZ_HALF, 1, 32'h10, 32'h0, 32'h00007FFF, 0));
    t.push_back(mk(1, SZ_HALF, 0, 32'h12, 32'hFFFFABCD, 32'h0, 0));
    t.push_back(mk(1, SZ_BYTE, 0, 32'h11, 32'h12345699, 32'h0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hABCD99FF, 0));
    t.push_back(mk(0, SZ_BYTE, 1, 32'h11, 32'h0, 32'hFFFFFF99, 0));
    run_table("ls", 1, t);
  endtask

  task automatic test_faults;
    txn_t t[$];
    t.push_back(mk(1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0));
    t.push_back(mk(1, SZ_WORD, 0, 32'h22, 32'h12345678, 32'h0, 1));
    t.push_back(mk(1, SZ_HALF, 0, 32'h21, 32'h00005555, 32'h0, 1));
    t.push_back(mk(1, 2'b11,   0, 32'h23, 32'h00000077, 32'h0, 1));
    t.push_back(mk(0, SZ_WORD, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0));
    t.push_back(mk(0, SZ_HALF, 1, 32'h21, 32'h0, 32'h0, 1));
    t.push_back(mk(0, SZ_WORD, 0, 32'h21, 32'h0, 32'h0, 1));
    t.push_back(mk(0, 2'b11,   0, 32'h20, 32'h0, 32'h0, 1));
    t.push_back(mk(0, SZ_HALF, 1, 32'h22, 32'h0, 32'hFFFFCAFE, 0));
    run_table("flt", 1, t);
  endtask

  task automatic test_wrap;
    txn_t t[$];
    t.push_back(mk(1, SZ_WORD, 0, 32'hFFFFF0A0, 32'h13579BDF, 32'h0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h000000A0, 32'h0, 32'h13579BDF, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h000010A0, 32'h0, 32'h13579BDF, 0));
    run_table("wrap", 1, t);
  endtask

  task automatic test_backpressure;
    txn_t t[$];
    txn_t ld, st;
    int lat;
    logic v, r, er;
    logic [31:0] rd;
    exp_t e;
    t.push_back(mk(1, SZ_WORD, 0, 32'h40, 32'h5555AAAA, 32'h0, 0));
    run_table("bp_pre", 3, t);
    ld = mk(0, SZ_WORD, 0, 32'h40, 32'h0, 32'h5555AAAA, 0);
    st = mk(1, SZ_WORD, 0, 32'h40, 32'h00000000, 32'h0, 0);
    sb.push_back(mk_exp("bp_load", 4, ld));
    issue(3, ld, lat, rd, er);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL %s latency got %0d want %0d", e.name, lat, e.lat); else passes++;
    for (int i = 0; i < 5; i++) begin
      set_req(3, 1'b1, st);
      @(negedge clk);
      sample(3, v, r, rd, er);
      checks++; if (v !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", i, v); else passes++;
      checks++; if (rd !== e.rdata) $display("FAIL bp_hold_rdata[%0d] got %h want %h", i, rd, e.rdata); else passes++;
      checks++; if (r !== 1'b0) $display("FAIL bp_hold_req_ready[%0d] got %b want 0", i, r); else passes++;
    end
    set_req(3, 1'b0, st);
    set_rsp_ready(3, 1'b1);
    @(negedge clk);
    set_rsp_ready(3, 1'b0);
    sample(3, v, r, rd, er);
    checks++; if (v !== 1'b0) $display("FAIL bp_after_hs_valid got %b want 0", v); else passes++;
    checks++; if (r !== 1'b1) $display("FAIL bp_after_hs_req_ready got %b want 1", r); else passes++;
    t.delete();
    t.push_back(mk(0, SZ_WORD, 0, 32'h40, 32'h0, 32'h5555AAAA, 0));
    run_table("bp_post", 3, t);
  endtask

  task automatic test_reset_mid;
    txn_t t[$];
    txn_t st, ld;
    int lat;
    logic v, r, er;
    logic [31:0] rd;
    t.push_back(mk(1, SZ_WORD, 0, 32'h30, 32'h0BADF00D, 32'h0, 0));
    run_table("rm_pre", 3, t);
    st = mk(1, SZ_WORD, 0, 32'h30, 32'hFFFFFFFF, 32'h0, 0);
    @(negedge clk);
    set_req(3, 1'b1, st);
    @(posedge clk);
    @(posedge clk);
    #2;
    set_req(3, 1'b0, st);
    sample(3, v, r, rd, er);
    checks++; if (r !== 1'b0) $display("FAIL rm_busy_req_ready got %b want 0", r); else passes++;
    rst = 1'b1;
    #1;
    sample(3, v, r, rd, er);
    checks++; if (r !== 1'b1) $display("FAIL rm_async_req_ready got %b want 1", r); else passes++;
    checks++; if (v !== 1'b0) $display("FAIL rm_async_rsp_valid got %b want 0", v); else passes++;
    @(negedge clk);
    rst = 1'b0;
    t.delete();
    t.push_back(mk(0, SZ_WORD, 0, 32'h30, 32'h0, 32'h0BADF00D, 0));
    run_table("rm_post", 3, t);
    // Reset while a response is waiting to be taken.
    ld = mk(0, SZ_WORD, 0, 32'h30, 32'h0, 32'h0BADF00D, 0);
    issue(3, ld, lat, rd, er);
    checks++; if (rd !== 32'h0BADF00D) $display("FAIL rm_resp_rdata got %h want 0badf00d", rd); else passes++;
    #2;
    rst = 1'b1;
    #1;
    sample(3, v, r, rd, er);
    checks++; if (v !== 1'b0) $display("FAIL rm_resp_discard_valid got %b want 0", v); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL rm_resp_discard_rdata got %h want 0", rd); else passes++;
    checks++; if (r !== 1'b1) $display("FAIL rm_resp_discard_req_ready got %b want 1", r); else passes++;
    @(negedge clk);
    rst = 1'b0;
`ifdef DM_STAT_EN
    checks++; if (s3_rd !== 16'h0) $display("FAIL rm_stat_rd got %0d want 0", s3_rd); else passes++;
    checks++; if (s3_wr !== 16'h0) $display("FAIL rm_stat_wr got %0d want 0", s3_wr); else passes++;
    checks++; if (s3_err !== 16'h0) $display("FAIL rm_stat_err got %0d want 0", s3_err); else passes++;
`endif
  endtask

`ifdef DM_STAT_EN
  task automatic test_stats;
    txn_t t[$];
    t.push_back(mk(0, SZ_WORD, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0));
    t.push_back(mk(0, SZ_BYTE, 0, 32'h20, 32'h0, 32'h0000000D, 0));
    t.push_back(mk(1, SZ_WORD, 0, 32'h24, 32'h01020304, 32'h0, 0));
    t.push_back(mk(1, SZ_HALF, 0, 32'h21, 32'h0, 32'h0, 1));
    run_table("stat", 1, t);
    checks++; if (s1_rd !== 16'd2) $display("FAIL stat_rd got %0d want 2", s1_rd); else passes++;
    checks++; if (s1_wr !== 16'd1) $display("FAIL stat_wr got %0d want 1", s1_wr); else passes++;
    checks++; if (s1_err !== 16'd1) $display("FAIL stat_err got %0d want 1", s1_err); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_store();
    test_faults();
    test_wrap();
    test_backpressure();
    test_reset_mid();
`ifdef DM_STAT_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
